// File: rtl/moving_average_ring_if.sv
// Sample/result bus for the moving-average filter.
// The master drives samples and control; the slave returns the averaged result.
interface moving_average_ring_if #(
  parameter int unsigned DATA_W = 10,
  parameter int unsigned SEL_W  = 3
);
  logic              ena;
  logic [DATA_W-1:0] data_in;
  logic              strobe_in;
  logic [SEL_W-1:0]  win_sel;
  logic              round_en;
  logic [DATA_W-1:0] data_out;
  logic              strobe_out;
  logic              primed;

  modport master (
    output ena, data_in, strobe_in, win_sel, round_en,
    input  data_out, strobe_out, primed
  );

  modport slave (
    input  ena, data_in, strobe_in, win_sel, round_en,
    output data_out, strobe_out, primed
  );
endinterface

// File: rtl/moving_average_ring.sv
// Power-of-two window moving average over a circular sample buffer.
// A running sum is updated on each strobe rising edge.
module moving_average_ring #(
  parameter int unsigned DATA_W     = 10,
  parameter int unsigned MAX_LOG2_N = 5,
  parameter int unsigned SEL_W      = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  moving_average_ring_if.slave  bus
);

  localparam int unsigned DEPTH  = 1 << MAX_LOG2_N;
  localparam int unsigned PTR_W  = MAX_LOG2_N;
  localparam int unsigned FILL_W = MAX_LOG2_N + 1;
  localparam int unsigned SUM_W  = DATA_W + MAX_LOG2_N;
  localparam int unsigned RND_W  = SUM_W + 1;
  localparam int unsigned KW     = $clog2(MAX_LOG2_N + 1);
  localparam logic [DATA_W-1:0] DMAX = {DATA_W{1'b1}};

  logic [DATA_W-1:0] r_buf [DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr, w_wr_ptr_d;
  logic [FILL_W-1:0] r_fill, w_fill_d;
  logic [SUM_W-1:0]  r_sum, w_sum_d;
  logic [KW-1:0]     r_k_q, w_k_q_d;
  logic [DATA_W-1:0] r_data_out, w_data_out_d;
  logic              r_primed, w_primed_d;
  logic              r_strobe_out;
  logic              r_strobe_d;

  logic              w_accept;
  logic              w_flush;
  logic [KW-1:0]     w_k_eff;
  logic [FILL_W-1:0] w_n;
  logic [PTR_W-1:0]  w_old_idx;
  logic [FILL_W-1:0] w_fill_base, w_fill_next;
  logic [SUM_W-1:0]  w_sum_base, w_sum_next;
  logic [DATA_W-1:0] w_oldest;
  logic [RND_W-1:0]  w_rnd, w_avg;
  logic [DATA_W-1:0] w_result;

  assign w_accept  = bus.strobe_in & ~r_strobe_d & bus.ena;
  assign w_k_eff   = (bus.win_sel > SEL_W'(MAX_LOG2_N)) ? KW'(MAX_LOG2_N) : KW'(bus.win_sel);
  assign w_flush   = bus.ena && (w_k_eff != r_k_q);
  assign w_n       = FILL_W'(1) << w_k_eff;
  // N == DEPTH aliases to wr_ptr itself: the slot about to be overwritten is the oldest
  assign w_old_idx = r_wr_ptr - w_n[PTR_W-1:0];

  // Running-sum datapath; a flush makes the incoming sample the first of the window
  always_comb begin
    w_fill_base = w_flush ? '0 : r_fill;
    w_sum_base  = w_flush ? '0 : r_sum;
    w_oldest    = (w_fill_base >= w_n) ? r_buf[w_old_idx] : '0;
    w_sum_next  = w_sum_base + SUM_W'(bus.data_in) - SUM_W'(w_oldest);
    w_fill_next = (w_fill_base == FILL_W'(DEPTH)) ? w_fill_base : w_fill_base + FILL_W'(1);
    w_rnd       = bus.round_en ? RND_W'(w_n >> 1) : '0;
    w_avg       = (RND_W'(w_sum_next) + w_rnd) >> w_k_eff;
    w_result    = (w_avg > RND_W'(DMAX)) ? DMAX : w_avg[DATA_W-1:0];
  end

  // Next-state selection
  always_comb begin
    w_wr_ptr_d   = r_wr_ptr;
    w_fill_d     = r_fill;
    w_sum_d      = r_sum;
    w_k_q_d      = r_k_q;
    w_data_out_d = r_data_out;
    w_primed_d   = r_primed;
    if (w_flush) begin
      w_k_q_d    = w_k_eff;
      w_fill_d   = '0;
      w_sum_d    = '0;
      w_primed_d = 1'b0;
    end
    if (w_accept) begin
      w_wr_ptr_d   = r_wr_ptr + PTR_W'(1);
      w_fill_d     = w_fill_next;
      w_sum_d      = w_sum_next;
      w_data_out_d = w_result;
      w_primed_d   = (w_fill_next >= w_n);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr     <= '0;
      r_fill       <= '0;
      r_sum        <= '0;
      r_k_q        <= '0;
      r_data_out   <= '0;
      r_primed     <= 1'b0;
      r_strobe_out <= 1'b0;
      r_strobe_d   <= 1'b0;
    end else begin
      r_wr_ptr     <= w_wr_ptr_d;
      r_fill       <= w_fill_d;
      r_sum        <= w_sum_d;
      r_k_q        <= w_k_q_d;
      r_data_out   <= w_data_out_d;
      r_primed     <= w_primed_d;
      r_strobe_out <= w_accept;
      r_strobe_d   <= bus.strobe_in;
    end
  end

  // Sample storage; stale contents are masked by fill
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_buf[r_wr_ptr] <= bus.data_in;
    end
  end

  assign bus.data_out   = r_data_out;
  assign bus.strobe_out = r_strobe_out;
  assign bus.primed     = r_primed;

endmodule

// File: doc/moving_average_ring.md
MOVING_AVERAGE_RING -- requirements
Module: moving_average_ring

Interface
REQ-001 Parameter DATA_W, default 10, sample width in bits (unsigned).
REQ-002 Parameter MAX_LOG2_N, default 5, log2 of maximum window length; buffer depth 2^MAX_LOG2_N.
REQ-003 Parameter SEL_W, default 3, width of win_sel; SHALL be at least clog2(MAX_LOG2_N+1).
REQ-004 clk  input  1  single clock; all state changes on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 ena  input  1  block enable; low = no sample accepted.
REQ-007 data_in  input  DATA_W  sample value.
REQ-008 strobe_in  input  1  level strobe; a sample is taken on its rising edge.
REQ-009 win_sel  input  SEL_W  window exponent k; window N = 2^k.
REQ-010 round_en  input  1  1 = round half-up, 0 = truncate.
REQ-011 data_out  output  DATA_W  registered average.
REQ-012 strobe_out  output  1  one-cycle pulse marking a new data_out.
REQ-013 primed  output  1  high once the window holds N real samples.

Function
REQ-014 strobe_in SHALL be registered every cycle, regardless of ena, into strobe_d.
REQ-015 Edge = strobe_in & ~strobe_d; accept = edge & ena.
REQ-016 Holding strobe_in high for many cycles SHALL produce exactly one accept.
REQ-017 Effective k SHALL be min(win_sel, MAX_LOG2_N); values above the maximum clamp.
REQ-018 Buffer SHALL be a circular RAM of 2^MAX_LOG2_N x DATA_W with write pointer wr_ptr.
REQ-019 wr_ptr SHALL wrap modulo 2^MAX_LOG2_N.
REQ-020 On accept: oldest = buf[(wr_ptr - N) mod depth] if fill >= N, else 0.
REQ-021 On accept: sum <= sum + data_in - oldest; buf[wr_ptr] <= data_in; wr_ptr <= wr_ptr+1.
REQ-022 sum width SHALL be DATA_W+MAX_LOG2_N and SHALL never overflow.
REQ-023 fill SHALL increment on accept and saturate at 2^MAX_LOG2_N.
REQ-024 Result = (sum_next + (round_en && k>0 ? 2^(k-1) : 0)) >> k.
REQ-025 Result SHALL be saturated to 2^DATA_W-1; this bound is unreachable by construction but is kept as a guard.
REQ-026 On accept, data_out SHALL be loaded and strobe_out SHALL be high for exactly the next cycle (latency 1 clock from the accepting edge).
REQ-027 During warm-up (fill < N), zeros stand in for missing samples; primed = 0.
REQ-028 primed SHALL equal (fill_next >= N), registered.
REQ-029 k = 0 SHALL give pass-through: data_out = data_in, primed after the first sample.
REQ-030 Window change: effective k is registered as k_q.
REQ-031 When effective k != k_q, sum and fill SHALL be cleared, primed SHALL be 0, k_q updated, and data_out held; wr_ptr and buffer are unchanged.
REQ-032 If a window change and an accept coincide, the flush applies first and the sample becomes the first of the new window (sum = data_in).
REQ-033 ena low SHALL hold all state except strobe_d; strobe_out = 0 while ena low.

Reset
REQ-034 rst_n low SHALL immediately clear data_out, strobe_out, primed, sum, fill, wr_ptr, strobe_d and k_q (k_q to 0).
REQ-035 Buffer contents need not reset; fill = 0 masks them.
REQ-036 Reset asserted mid-window SHALL discard all history; the first accept after release starts a new warm-up.

Verification
REQ-037 Reset: assert rst_n=0 mid-stream -> data_out=0, strobe_out=0, primed=0 without waiting for a clock edge.
REQ-038 k=2, round_en=0, samples 100, 200, 300, 400, 500 -> data_out 25, 75, 150, 250, 350; primed rises with the 4th output.
REQ-039 Rounding: k=1, samples 1 then 2 -> round_en=1 gives 1, 2; round_en=0 gives 0, 1.
REQ-040 Full scale: k=5, 40 samples of 1023 -> output ramps and holds 1023 from the 32nd sample; no wrap; wr_ptr wraps cleanly.
REQ-041 Window switch: primed at k=2, then k=1 together with sample 60 -> out 30, primed 0; next sample 40 -> out 50, primed 1.
REQ-042 Handshake: strobe_in high for 10 cycles -> one strobe_out pulse; edge with ena=0 -> no pulse, no state change; ena re-raised while strobe_in high -> no pulse.
